// File: rtl/prog_loader_pkg.sv
// +--------------------------------------------------------------------------+
// | prog_loader_pkg : state encodings, error codes and header-length check   |
// |                   shared by the program loader.                          |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

package prog_loader_pkg;

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_LOAD   = 3'd1;
  localparam logic [2:0] c_ST_CSUM   = 3'd2;
  localparam logic [2:0] c_ST_COMMIT = 3'd3;
  localparam logic [2:0] c_ST_RUN    = 3'd4;
  localparam logic [2:0] c_ST_ERR    = 3'd5;

  typedef logic [1:0] err_code_t;

  localparam err_code_t c_ERR_NONE = 2'd0;
  localparam err_code_t c_ERR_LEN  = 2'd1;
  localparam err_code_t c_ERR_LAST = 2'd2;
  localparam err_code_t c_ERR_CSUM = 2'd3;

  // A header length must address at least one word and fit the frame memory.
  function automatic logic hdr_len_bad(input logic [31:0] len, input logic [31:0] limit);
    return (len == 32'd0) || (len > limit);
  endfunction

endpackage

`default_nettype wire

// File: rtl/prog_loader_ctrl.sv
// +--------------------------------------------------------------------------+
// | prog_loader_ctrl : load sequencer FSM, word counter and error tracking.  |
// |                    Trailing checksum word enabled by                     |
// |                    PROG_LOADER_CHECKSUM_EN.                              |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module prog_loader_ctrl
  import prog_loader_pkg::*;
#(
  parameter int DATA_DEPTH = 1024,
  parameter int INSTR_SIZE = 16,
  parameter int CNT_W      = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [INSTR_SIZE-1:0] in_data,
  input  logic                  in_last,
  input  logic                  prog_end,
  input  logic                  err_clr,
  output logic                  in_ready,
  output logic                  img_clr,
  output logic                  img_we,
  output logic [CNT_W-1:0]      img_addr,
  output logic                  prog_loading,
  output logic                  busy,
  output logic                  err,
  output err_code_t             err_code,
  output logic [CNT_W-1:0]      word_cnt
);

  logic [2:0]            r_state;
  logic [CNT_W-1:0]      r_len;
  logic [CNT_W-1:0]      r_cnt;
  logic [INSTR_SIZE-1:0] r_xor;
  err_code_t             r_code;
  logic                  r_prog_loading;

  logic w_beat;
  logic w_hdr_bad;
  logic w_final;

  assign in_ready  = (r_state == c_ST_IDLE) || (r_state == c_ST_LOAD) || (r_state == c_ST_CSUM);
  assign w_beat    = in_valid & in_ready;
  assign w_hdr_bad = hdr_len_bad(32'(in_data), 32'(DATA_DEPTH)) | in_last;
  assign w_final   = (r_cnt == r_len - 1'b1);

  assign img_clr      = (r_state == c_ST_IDLE) & w_beat & ~w_hdr_bad;
  assign img_we       = (r_state == c_ST_LOAD) & w_beat;
  assign img_addr     = r_cnt;
  assign prog_loading = r_prog_loading;
  assign busy         = (r_state == c_ST_LOAD) || (r_state == c_ST_CSUM) ||
                        (r_state == c_ST_COMMIT) || (r_state == c_ST_RUN);
  assign err          = (r_state == c_ST_ERR);
  assign err_code     = r_code;
  assign word_cnt     = r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= c_ST_IDLE;
      r_len          <= '0;
      r_cnt          <= '0;
      r_xor          <= '0;
      r_code         <= c_ERR_NONE;
      r_prog_loading <= 1'b0;
    end else begin
      r_prog_loading <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_beat) begin
            if (w_hdr_bad) begin
              r_state <= c_ST_ERR;
              r_code  <= c_ERR_LEN;
            end else begin
              r_len   <= CNT_W'(in_data);
              r_cnt   <= '0;
              r_xor   <= '0;
              r_state <= c_ST_LOAD;
            end
          end
        end
        c_ST_LOAD: begin
          if (w_beat) begin
            r_cnt <= r_cnt + 1'b1;
            r_xor <= r_xor ^ in_data;
            if (w_final) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              // The checksum word, not the last data word, closes the stream.
              if (in_last) begin
                r_state <= c_ST_ERR;
                r_code  <= c_ERR_LAST;
              end else begin
                r_state <= c_ST_CSUM;
              end
`else
              if (in_last) begin
                r_state        <= c_ST_COMMIT;
                r_prog_loading <= 1'b1;
              end else begin
                r_state <= c_ST_ERR;
                r_code  <= c_ERR_LAST;
              end
`endif
            end else if (in_last) begin
              r_state <= c_ST_ERR;
              r_code  <= c_ERR_LAST;
            end
          end
        end
        c_ST_CSUM: begin
          if (w_beat) begin
            if (!in_last) begin
              r_state <= c_ST_ERR;
              r_code  <= c_ERR_LAST;
            end else if (in_data != r_xor) begin
              r_state <= c_ST_ERR;
              r_code  <= c_ERR_CSUM;
            end else begin
              r_state        <= c_ST_COMMIT;
              r_prog_loading <= 1'b1;
            end
          end
        end
        c_ST_COMMIT: r_state <= c_ST_RUN;
        c_ST_RUN: begin
          if (prog_end) r_state <= c_ST_IDLE;
        end
        c_ST_ERR: begin
          if (err_clr) begin
            r_state <= c_ST_IDLE;
            r_code  <= c_ERR_NONE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// +--------------------------------------------------------------------------+
// | prog_loader : builds the scheduler frame-memory image from a host word   |
// |               stream and strobes prog_loading on commit.                 |
// |               Optional checksum word: PROG_LOADER_CHECKSUM_EN.           |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DATA_DEPTH = 1024,
  parameter int INSTR_SIZE = 16,
  parameter int CNT_W      = 11
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [INSTR_SIZE-1:0]                 in_data,
  input  logic                                  in_last,
  input  logic                                  prog_end,
  input  logic                                  err_clr,
  output logic [DATA_DEPTH-1:0][INSTR_SIZE-1:0] data_frames_out,
  output logic                                  prog_loading,
  output logic                                  busy,
  output logic                                  err,
  output logic [1:0]                            err_code,
  output logic [CNT_W-1:0]                      word_cnt
);

  localparam int c_AW = $clog2(DATA_DEPTH);

  logic [DATA_DEPTH-1:0][INSTR_SIZE-1:0] r_img;
  logic                                  w_img_clr;
  logic                                  w_img_we;
  logic [CNT_W-1:0]                      w_img_addr;
  logic                                  w_unused_addr_msb;

  prog_loader_ctrl #(
    .DATA_DEPTH (DATA_DEPTH),
    .INSTR_SIZE (INSTR_SIZE),
    .CNT_W      (CNT_W)
  ) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .prog_end     (prog_end),
    .err_clr      (err_clr),
    .in_ready     (in_ready),
    .img_clr      (w_img_clr),
    .img_we       (w_img_we),
    .img_addr     (w_img_addr),
    .prog_loading (prog_loading),
    .busy         (busy),
    .err          (err),
    .err_code     (err_code),
    .word_cnt     (word_cnt)
  );

  // The controller only writes while word_cnt < length <= DATA_DEPTH.
  assign w_unused_addr_msb = ^w_img_addr[CNT_W-1:c_AW];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_img <= '0;
    end else if (w_img_clr) begin
      r_img <= '0;
    end else if (w_img_we) begin
      r_img[w_img_addr[c_AW-1:0]] <= in_data;
    end
  end

  assign data_frames_out = r_img;

endmodule

`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Sequences program loading into the scheduler.
- Accepts a word stream from the host (valid/ready), builds the full frame-memory image, then pulses prog_loading for one cycle so the scheduler copies the image.
- Holds off new loads while the scheduler runs and reports malformed streams.
- Sits between the host interface and the scheduler's data_frames_in/prog_loading inputs.

Parameters:
DATA_DEPTH, 1024, words in program image (scheduler frame memory depth)
INSTR_SIZE, 16, bits per word
CNT_W, 11, width of word counter/length (must hold DATA_DEPTH)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  host word valid
in_ready  output  1  loader can accept a word
in_data  input  INSTR_SIZE  host word
in_last  input  1  marks final word of a stream
prog_end  input  1  scheduler finished program (end-of-program indication)
err_clr  input  1  clears error state
data_frames_out  output  DATA_DEPTH x INSTR_SIZE  image to scheduler data_frames_in
prog_loading  output  1  one-cycle commit strobe to scheduler
busy  output  1  high in LOAD/CSUM/COMMIT/RUN
err  output  1  high in ERR
err_code  output  2  0 none, 1 bad length, 2 early/late last, 3 checksum
word_cnt  output  CNT_W  data words accepted in current stream

Behaviour:
- Beat = in_valid & in_ready. in_ready is combinational from state: high in IDLE, LOAD and CSUM; low otherwise. in_data is ignored when no beat occurs.
- Reset (reset=0, async): state IDLE; image all zero; prog_loading=0, err=0, err_code=0, word_cnt=0, length reg=0.
- IDLE: a beat carries the header (length L).
  - L==0, L>DATA_DEPTH, or in_last=1 on the header -> ERR, err_code=1.
  - Otherwise latch L, clear the entire image to zero in the same edge, word_cnt<=0 -> LOAD.
- LOAD: each beat writes in_data to image[word_cnt], word_cnt++.
  - Beat with word_cnt==L-1: if in_last=1 -> COMMIT (CSUM when CHECKSUM_EN); if in_last=0 -> ERR, code 2.
  - Beat with in_last=1 and word_cnt<L-1 -> write the word, then ERR, code 2.
- COMMIT: prog_loading=1 for exactly one cycle (registered output, asserted the cycle after the final beat) -> RUN.
- RUN: in_ready=0, image stable. prog_end=1 -> IDLE. prog_end is ignored in all other states.
- ERR: in_ready=0; image retains all words written so far; prog_loading is never asserted. err_clr=1 -> IDLE, err=0, err_code=0. err_clr is ignored outside ERR.
- word_cnt holds its value through COMMIT/RUN/ERR and is reset only by the next header.
- Reset mid-load or mid-run aborts immediately; no prog_loading pulse.
- Image words beyond L stay zero.
- Latency: last beat at edge N -> prog_loading high during cycle N+1 (no checksum) or one beat later (checksum).

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- With it defined:
  - State CSUM follows LOAD. The last data word must have in_last=0.
  - The next beat is a checksum word, which must carry in_last=1 and must equal the XOR of all L data words.
  - Match -> COMMIT. Mismatch -> ERR, code 3. Checksum word without in_last -> ERR, code 2.
  - The running XOR resets at the header.
- Without it: no CSUM state; code 3 is never produced.

Decomposition:
- Shared package/defines file: state encodings (IDLE, LOAD, CSUM, COMMIT, RUN, ERR), err_code constants, the header-length limit.
- One sub-module is natural: prog_loader_ctrl (FSM, counter, error logic). The top holds the image array and write decode.

Test Plan:
1. Header 3, words 0x0011, 0x0022, 0x0033 (last on third) -> prog_loading single pulse; image[0..2] match; image[3..1023]=0; busy=1 until prog_end pulse, then IDLE with in_ready=1.
2. Header 0 -> err=1, err_code=1, no prog_loading; err_clr -> IDLE, err=0.
3. Header 4, three words with in_last on the third -> err_code=2, image[0..2] written, prog_loading never asserted.
4. Header 1024, 1024 words with in_valid toggled randomly -> image[1023] holds the final word, word_cnt=1024, one commit pulse.
5. Reset asserted after 2 of 5 words -> all outputs zero immediately; a subsequent full stream loads correctly.
6. (CHECKSUM_EN) Header 2, words 0x00F0, 0x0F00, checksum 0x0FF0 -> commit. Same stream with checksum 0x0FF1 -> err_code=3.
